// File: rtl/k16_fb_fill.sv
// Frame-buffer fill engine: CPU-programmed block fill streamed into the frame
// buffer write port, with CPU writes taking priority on that port.
module k16_fb_fill #(
  parameter int FB_AW = 11,
  parameter int DW    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       reg_addr,
  input  logic [15:0]      reg_din,
  input  logic             reg_write,
  output logic [15:0]      reg_dout,
  input  logic             cpu_fb_write,
  input  logic [FB_AW-1:0] cpu_fb_waddr,
  input  logic [DW-1:0]    cpu_fb_din,
  output logic             fb_write,
  output logic [FB_AW-1:0] fb_waddr,
  output logic [DW-1:0]    fb_din,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0]    MAX_COUNT = 16'(2 ** FB_AW);
  localparam logic [FB_AW:0] REM_ONE   = (FB_AW + 1)'(1);
  localparam logic [FB_AW-1:0] PTR_ONE = FB_AW'(1);
  localparam logic [DW-1:0]  CUR_ONE   = DW'(1);

  state_t           state_r;
  logic [FB_AW-1:0] start_r;
  logic [FB_AW:0]   count_r;
  logic [DW-1:0]    value_r;
  logic             inc_r;
  logic             inc_run_r;
  logic [FB_AW-1:0] ptr_r;
  logic [FB_AW:0]   rem_r;
  logic [DW-1:0]    cur_r;

  logic ctrl_wr;
  logic go_req;
  logic abort_req;
  logic eng_write;

  assign ctrl_wr   = reg_write && (reg_addr == 2'd3);
  assign go_req    = ctrl_wr && reg_din[0];
  assign abort_req = ctrl_wr && reg_din[2];
  // An abort cycle and a CPU cycle both suppress the engine write.
  assign eng_write = (state_r == FILL) && !abort_req && !cpu_fb_write;

  assign busy = (state_r == FILL);
  assign done = (state_r == DONE);

  // Register file and fill sequencer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= IDLE;
      start_r   <= '0;
      count_r   <= '0;
      value_r   <= '0;
      inc_r     <= 1'b0;
      inc_run_r <= 1'b0;
      ptr_r     <= '0;
      rem_r     <= '0;
      cur_r     <= '0;
    end else begin
      if (reg_write) begin
        case (reg_addr)
          2'd0:    start_r <= reg_din[FB_AW-1:0];
          2'd1:    count_r <= (reg_din > MAX_COUNT) ? MAX_COUNT[FB_AW:0] : reg_din[FB_AW:0];
          2'd2:    value_r <= reg_din[DW-1:0];
          2'd3:    inc_r   <= reg_din[1];
          default: ;
        endcase
      end

      case (state_r)
        IDLE: begin
          if (go_req && !abort_req) begin
            if (count_r != '0) begin
              ptr_r     <= start_r;
              rem_r     <= count_r;
              cur_r     <= value_r;
              inc_run_r <= reg_din[1];
              state_r   <= FILL;
            end else begin
              state_r <= DONE;
            end
          end
        end
        FILL: begin
          if (abort_req) begin
            state_r <= DONE;
          end else if (!cpu_fb_write) begin
            ptr_r <= ptr_r + PTR_ONE;
            rem_r <= rem_r - REM_ONE;
            cur_r <= cur_r + (inc_run_r ? CUR_ONE : '0);
            if (rem_r == REM_ONE) begin
              state_r <= DONE;
            end
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Register readback.
  always_comb begin
    reg_dout = 16'd0;
    case (reg_addr)
      2'd0:    reg_dout = 16'(start_r);
      2'd1:    reg_dout = 16'(count_r);
      2'd2:    reg_dout = 16'(value_r);
      2'd3:    reg_dout = {14'd0, inc_r, busy};
      default: reg_dout = 16'd0;
    endcase
  end

  // Frame-buffer port mux; the CPU always wins.
  always_comb begin
    fb_write = 1'b0;
    fb_waddr = '0;
    fb_din   = '0;
    if (cpu_fb_write) begin
      fb_write = 1'b1;
      fb_waddr = cpu_fb_waddr;
      fb_din   = cpu_fb_din;
    end else if (eng_write) begin
      fb_write = 1'b1;
      fb_waddr = ptr_r;
      fb_din   = cur_r;
    end else begin
      fb_write = 1'b0;
      fb_waddr = '0;
      fb_din   = '0;
    end
  end

endmodule

// File: tb/tb_k16_fb_fill.sv
// Scoreboard bench for k16_fb_fill: expected frame-buffer writes are queued by
// the stimulus and popped by an independent monitor.
module tb_k16_fb_fill;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  reg_addr;
  logic [15:0] reg_din;
  logic        reg_write;
  logic [15:0] reg_dout;
  logic        cpu_fb_write;
  logic [10:0] cpu_fb_waddr;
  logic [15:0] cpu_fb_din;
  logic        fb_write;
  logic [10:0] fb_waddr;
  logic [15:0] fb_din;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [10:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  k16_fb_fill #(.FB_AW(11), .DW(16)) dut (
    .clk(clk), .reset(reset),
    .reg_addr(reg_addr), .reg_din(reg_din), .reg_write(reg_write), .reg_dout(reg_dout),
    .cpu_fb_write(cpu_fb_write), .cpu_fb_waddr(cpu_fb_waddr), .cpu_fb_din(cpu_fb_din),
    .fb_write(fb_write), .fb_waddr(fb_waddr), .fb_din(fb_din),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every frame-buffer write must match the head of the queue.
  always @(negedge clk) begin
    if (reset === 1'b1 || reset === 1'b0) begin
      if (fb_write) begin
        if (exp_q.size() == 0) begin
          check("unexpected_fb_write", {5'd0, fb_waddr, fb_din}, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("fb_waddr", {21'd0, fb_waddr}, {21'd0, e.a});
          check("fb_din", {16'd0, fb_din}, {16'd0, e.d});
        end
      end else begin
        check("fb_idle_bus", {5'd0, fb_waddr, fb_din}, 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reg(input logic [1:0] a, input logic [15:0] d);
    reg_addr  = a;
    reg_din   = d;
    reg_write = 1'b1;
    next_cycle();
    reg_write = 1'b0;
  endtask

  task automatic read_reg(input string name, input logic [1:0] a, input logic [15:0] exp);
    reg_addr = a;
    #1;
    check(name, {16'd0, reg_dout}, {16'd0, exp});
  endtask

  task automatic go(input bit inc);
    set_reg(2'd3, {14'd0, inc, 1'b1});
  endtask

  function automatic wr_t eng_item(input int start, input int value, input bit inc, input int i);
    wr_t w;
    w.a = 11'((start + i) % 2048);
    w.d = 16'(inc ? (value + i) : value);
    return w;
  endfunction

  // Runs one fill from GO to done; CPU writes stall it on chosen/random cycles.
  task automatic run_fill(input int start, input int count, input int value, input bit inc,
                          input int stall_pct, input logic [31:0] stall_mask,
                          input bit prog, input bit poke);
    int  eng;
    int  cyc;
    bit  cpu;
    wr_t w;
    if (prog) begin
      set_reg(2'd0, 16'(start));
      set_reg(2'd1, 16'(count));
      set_reg(2'd2, 16'(value));
    end
    go(inc);
    eng = 0;
    cyc = 0;
    while (eng < count) begin
      cpu = ((cyc < 32) && stall_mask[cyc]) || (int'($urandom_range(99)) < stall_pct);
      cpu_fb_write = cpu;
      if (cpu) begin
        w.a = 11'($urandom);
        w.d = 16'($urandom);
        cpu_fb_waddr = w.a;
        cpu_fb_din   = w.d;
      end else begin
        w = eng_item(start, value, inc, eng);
        eng++;
      end
      exp_q.push_back(w);
      if (poke && cyc < 4) begin
        reg_addr  = 2'(cyc);
        reg_write = 1'b1;
        case (cyc)
          0:       reg_din = 16'h0155;
          1:       reg_din = 16'd5;
          2:       reg_din = 16'hBEEF;
          default: reg_din = 16'h0003;
        endcase
      end else begin
        reg_write = 1'b0;
      end
      @(negedge clk);
      check("busy_during_fill", {31'd0, busy}, 32'd1);
      next_cycle();
      cyc++;
    end
    cpu_fb_write = 1'b0;
    reg_write    = 1'b0;
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("done_single", {31'd0, done}, 32'd0);
    next_cycle();
  endtask

  initial begin
    reset        = 1'b0;
    reg_addr     = 2'd0;
    reg_din      = 16'd0;
    reg_write    = 1'b0;
    cpu_fb_write = 1'b0;
    cpu_fb_waddr = 11'd0;
    cpu_fb_din   = 16'd0;
    repeat (3) next_cycle();
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 4; i++) read_reg("reset_reg", 2'(i), 16'd0);
    reset = 1'b1;
    next_cycle();

    // register clamping and readback
    set_reg(2'd1, 16'h0801); read_reg("count_clamp_2049", 2'd1, 16'd2048);
    set_reg(2'd1, 16'h0800); read_reg("count_2048", 2'd1, 16'd2048);
    set_reg(2'd1, 16'h07FF); read_reg("count_2047", 2'd1, 16'd2047);
    set_reg(2'd1, 16'hFFFF); read_reg("count_clamp_ffff", 2'd1, 16'd2048);
    set_reg(2'd0, 16'hFFFF); read_reg("start_mask", 2'd0, 16'h07FF);
    set_reg(2'd2, 16'hA5C3); read_reg("value_rd", 2'd2, 16'hA5C3);
    set_reg(2'd3, 16'h0002); read_reg("ctrl_inc", 2'd3, 16'h0002);
    set_reg(2'd3, 16'h0000); read_reg("ctrl_clear", 2'd3, 16'h0000);

    // idle CPU write passes straight through
    cpu_fb_write = 1'b1; cpu_fb_waddr = 11'h3A5; cpu_fb_din = 16'h5A5A;
    exp_q.push_back(wr_t'{a: 11'h3A5, d: 16'h5A5A});
    next_cycle();
    cpu_fb_write = 1'b0;

    run_fill(0, 2048, 16'h0020, 1'b0, 0, 32'd0, 1'b1, 1'b0);
    run_fill(2046, 4, 16'h0100, 1'b1, 0, 32'd0, 1'b1, 1'b0);
    run_fill(100, 8, 16'h1234, 1'b1, 0, 32'b11010, 1'b1, 1'b0);
    run_fill(2040, 12, 16'hFFFA, 1'b1, 0, 32'd0, 1'b1, 1'b0);

    // shadow-register writes and GO during a fill leave it untouched
    run_fill(500, 10, 16'h7777, 1'b0, 0, 32'd0, 1'b1, 1'b1);
    read_reg("poke_start", 2'd0, 16'h0155);
    read_reg("poke_count", 2'd1, 16'd5);
    read_reg("poke_value", 2'd2, 16'hBEEF);
    read_reg("poke_ctrl", 2'd3, 16'h0002);

    for (int k = 0; k < 6; k++) begin
      run_fill(int'($urandom_range(2047)), int'($urandom_range(40, 1)), int'($urandom_range(65535)),
               1'($urandom_range(1)), 25, 32'd0, 1'b1, 1'b0);
    end

    // COUNT=0: done on the next cycle with no writes
    set_reg(2'd1, 16'd0);
    go(1'b0);
    @(negedge clk);
    check("zero_count_done", {31'd0, done}, 32'd1);
    check("zero_count_busy", {31'd0, busy}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("zero_count_done_end", {31'd0, done}, 32'd0);
    next_cycle();

    // GO together with ABORT in IDLE does nothing
    set_reg(2'd1, 16'd10);
    set_reg(2'd3, 16'h0005);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("goabort_busy", {31'd0, busy}, 32'd0);
      check("goabort_done", {31'd0, done}, 32'd0);
      next_cycle();
    end

    // abort after 5 of 100 words, then restart from START
    set_reg(2'd0, 16'd300);
    set_reg(2'd1, 16'd100);
    set_reg(2'd2, 16'h4242);
    go(1'b0);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(eng_item(300, 16'h4242, 1'b0, i));
      @(negedge clk);
      check("abort_busy", {31'd0, busy}, 32'd1);
      next_cycle();
    end
    reg_addr = 2'd3; reg_din = 16'h0004; reg_write = 1'b1;
    @(negedge clk);
    check("abort_no_write", {31'd0, fb_write}, 32'd0);
    next_cycle();
    reg_write = 1'b0;
    @(negedge clk);
    check("abort_done", {31'd0, done}, 32'd1);
    check("abort_busy_low", {31'd0, busy}, 32'd0);
    next_cycle();
    run_fill(300, 100, 16'h4242, 1'b0, 0, 32'd0, 1'b0, 1'b0);

    // reset mid-fill: no done, registers cleared, COUNT write during reset lost
    set_reg(2'd0, 16'd50);
    set_reg(2'd1, 16'd100);
    set_reg(2'd2, 16'd1);
    go(1'b1);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(eng_item(50, 1, 1'b1, i));
      next_cycle();
    end
    exp_q.push_back(eng_item(50, 1, 1'b1, 3));
    reset = 1'b0; reg_addr = 2'd1; reg_din = 16'h1FFF; reg_write = 1'b1;
    next_cycle();
    reg_write = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_no_done", {31'd0, done}, 32'd0);
      next_cycle();
    end
    for (int i = 0; i < 4; i++) read_reg("rst_reg_zero", 2'(i), 16'd0);
    reset = 1'b1;
    next_cycle();
    set_reg(2'd1, 16'h1FFF);
    read_reg("count_after_rst", 2'd1, 16'd2048);

    repeat (3) next_cycle();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
